// File: rtl/window_average_dump_pkg.sv
// Shared definitions for the window averager: FSM state type, FIFO depth
// and a generic signed saturation helper.
package window_avg_pkg;

    localparam int FIFO_DEPTH = 2;

    typedef enum logic [0:0] {
        COUNT   = 1'b0,
        CAPTURE = 1'b1
    } state_e;

    // Clamp a signed value into the range of a signed 'width'-bit number.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int                width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/window_average_dump_if.sv
// Valid/ready stream carrying one signed window average per transfer.
// The producer drives data/valid, the consumer drives ready.
interface window_average_dump_if #(
    parameter int OUT_W = 15
);
    logic [OUT_W-1:0] avg_data;
    logic             avg_valid;
    logic             avg_ready;

    modport master (output avg_data, output avg_valid, input avg_ready);
    modport slave  (input avg_data, input avg_valid, output avg_ready);
endinterface

// File: rtl/window_average_dump_result_fifo2.sv
// Two-entry in-order result FIFO. A push into a full FIFO is accepted only
// when a pop happens on the same edge; otherwise it is dropped and flagged.
module result_fifo2
    import window_avg_pkg::*;
#(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o,
    output logic             push_drop_o
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic             pop;
    logic             push_ok;

    assign valid_o     = (count_q != 2'd0);
    assign full_o      = (count_q == 2'(FIFO_DEPTH));
    assign pop         = valid_o && ready_i;
    assign push_ok     = push_i && (!full_o || pop);
    assign push_drop_o = push_i && full_o && !pop;
    assign data_o      = mem_q[rd_ptr_q];

    // Occupancy after this edge's push and pop.
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push_ok && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
        end
    end

    // Per-entry storage; an entry changes only when it is the write target.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                mem_q[gi] <= '0;
            end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
                mem_q[gi] <= data_i;
            end
        end
    end

endmodule

// File: rtl/window_average_dump.sv
// Per-window average of a free-running accumulator sum.
// Counts sample_en pulses; every 2^LOG2_WIN samples it takes the modular
// difference to the previous snapshot, shifts it down, saturates it and
// queues it in a 2-entry FIFO. Optional macro WINDOW_AVERAGE_ROUND_EN turns
// the floor shift into round-half-up.
module window_average_dump
    import window_avg_pkg::*;
#(
    parameter int SUM_W    = 25,
    parameter int LOG2_WIN = 4,
    parameter int IN_W     = 15,
    parameter int OUT_W    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_en,
    input  logic [SUM_W-1:0]      sum_in,
    window_average_dump_if.master avg_bus,
    output logic                  ovf
);

    // Window sum must not be able to wrap, and the helper works at 64 bits.
    if (IN_W + LOG2_WIN > SUM_W) begin : g_bad_width
        $error("window_average_dump: IN_W + LOG2_WIN exceeds SUM_W");
    end
    if (LOG2_WIN < 1 || SUM_W > 62 || OUT_W < 2) begin : g_bad_param
        $error("window_average_dump: unsupported parameter combination");
    end

    localparam logic [LOG2_WIN-1:0] CNT_MAX = '1;

    state_e              state_q;
    state_e              state_d;
    logic [LOG2_WIN-1:0] cnt_q;
    logic [SUM_W-1:0]    base_q;
    logic [OUT_W-1:0]    res_q;
    logic                res_vld_q;
    logic                ovf_q;

    logic signed [SUM_W-1:0] diff_w;
    logic signed [SUM_W:0]   ext_w;
    logic signed [SUM_W:0]   shifted_w;
    logic signed [63:0]      sat_w;
    logic                    sat_unused;
    logic [OUT_W-1:0]        avg_w;
    logic                    push_drop_w;
    logic                    full_unused;

    // Modular difference: correct window sum even after the sum wraps.
    assign diff_w = sum_in - base_q;

`ifdef WINDOW_AVERAGE_ROUND_EN
    localparam logic signed [SUM_W:0] RND = {{SUM_W{1'b0}}, 1'b1} << (LOG2_WIN - 1);
    assign ext_w = {diff_w[SUM_W-1], diff_w} + RND;
`else
    assign ext_w = {diff_w[SUM_W-1], diff_w};
`endif

    assign shifted_w  = ext_w >>> LOG2_WIN;
    assign sat_w      = sat_signed({{(63 - SUM_W){shifted_w[SUM_W]}}, shifted_w}, OUT_W);
    assign avg_w      = sat_w[OUT_W-1:0];
    assign sat_unused = ^sat_w[63:OUT_W];

    // Enter CAPTURE for one cycle after the last sample of a window.
    always_comb begin
        state_d = COUNT;
        if (sample_en && (cnt_q == CNT_MAX)) begin
            state_d = CAPTURE;
        end
    end

    // Sample counting, snapshot and result register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= COUNT;
            cnt_q     <= '0;
            base_q    <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_vld_q <= (state_q == CAPTURE);
            if (sample_en) begin
                cnt_q <= cnt_q + LOG2_WIN'(1);
            end
            if (state_q == CAPTURE) begin
                base_q <= sum_in;
                res_q  <= avg_w;
            end
        end
    end

    // Sticky overflow: set whenever a result is dropped by the full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (push_drop_w) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;

    result_fifo2 #(
        .WIDTH (OUT_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (res_vld_q),
        .data_i      (res_q),
        .ready_i     (avg_bus.avg_ready),
        .data_o      (avg_bus.avg_data),
        .valid_o     (avg_bus.avg_valid),
        .full_o      (full_unused),
        .push_drop_o (push_drop_w)
    );

endmodule

// File: tb/tb_window_average_dump.sv
// Scoreboard bench for window_average_dump: stimulus pushes expected window
// averages into per-DUT queues, monitors pop and compare on every transfer.
// A second instance with OUT_W=8 exercises saturation.
module tb_window_average_dump;

    logic        clk;
    logic        reset;
    logic        en15;
    logic        en8;
    logic [24:0] x_in;
    logic [24:0] acc;
    logic        rdy15;
    logic        rdy8;
    logic        ovf15;
    logic        ovf8;

    int total;
    int bad;
    int q15[$];
    int q8[$];

    window_average_dump_if #(.OUT_W(15)) bus15 ();
    window_average_dump_if #(.OUT_W(8))  bus8 ();

    assign bus15.avg_ready = rdy15;
    assign bus8.avg_ready  = rdy8;

    window_average_dump #(
        .SUM_W(25), .LOG2_WIN(4), .IN_W(15), .OUT_W(15)
    ) dut15 (
        .clk(clk), .reset(reset), .sample_en(en15), .sum_in(acc),
        .avg_bus(bus15), .ovf(ovf15)
    );

    window_average_dump #(
        .SUM_W(25), .LOG2_WIN(4), .IN_W(15), .OUT_W(8)
    ) dut8 (
        .clk(clk), .reset(reset), .sample_en(en8), .sum_in(acc),
        .avg_bus(bus8), .ovf(ovf8)
    );

    always #5 clk = ~clk;

    // Upstream accumulator model: adds a sign-extended sample on enable.
    always @(posedge clk or posedge reset) begin
        if (reset) acc <= '0;
        else if (en15 || en8) acc <= acc + x_in;
    end

    // Monitor for the 15-bit instance.
    always @(negedge clk) begin
        if (!reset && bus15.avg_valid && rdy15) begin
            int got;
            int exp_v;
            got = int'($signed(bus15.avg_data));
            total++;
            if (q15.size() == 0) begin
                bad++;
                $display("FAIL out15_unexpected got=%0d required=none", got);
            end else begin
                exp_v = q15.pop_front();
                if (got != exp_v) begin
                    bad++;
                    $display("FAIL out15_data got=%0d required=%0d", got, exp_v);
                end else begin
                    $display("out15 data=%0d ok", got);
                end
            end
        end
    end

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (!reset && bus8.avg_valid && rdy8) begin
            int got;
            int exp_v;
            got = int'($signed(bus8.avg_data));
            total++;
            if (q8.size() == 0) begin
                bad++;
                $display("FAIL out8_unexpected got=%0d required=none", got);
            end else begin
                exp_v = q8.pop_front();
                if (got != exp_v) begin
                    bad++;
                    $display("FAIL out8_data got=%0d required=%0d", got, exp_v);
                end else begin
                    $display("out8 data=%0d ok", got);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end else begin
            $display("check %s value=%0d ok", name, got);
        end
    endtask

    task automatic samp15(input int v);
        en15 = 1'b1;
        x_in = 25'(v);
        tick();
        en15 = 1'b0;
    endtask

    task automatic samp8(input int v);
        en8  = 1'b1;
        x_in = 25'(v);
        tick();
        en8  = 1'b0;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic drain15(input string name);
        for (int i = 0; i < 60; i++) begin
            if (q15.size() == 0 && !bus15.avg_valid) break;
            tick();
        end
        check(name, q15.size(), 0);
    endtask

    task automatic drain8(input string name);
        for (int i = 0; i < 60; i++) begin
            if (q8.size() == 0 && !bus8.avg_valid) break;
            tick();
        end
        check(name, q8.size(), 0);
    endtask

    function automatic int rnd_or(input int floor_v, input int round_v);
`ifdef WINDOW_AVERAGE_ROUND_EN
        return round_v;
`else
        return floor_v;
`endif
    endfunction

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        reset = 1'b1;
        en15  = 1'b0;
        en8   = 1'b0;
        x_in  = '0;
        rdy15 = 1'b0;
        rdy8  = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_valid", int'(bus15.avg_valid), 0);
        check("rst_data", int'(bus15.avg_data), 0);
        check("rst_ovf", int'(ovf15), 0);
        reset = 1'b0;
        tick();

        // 1: +3 per sample, exact latency of avg_valid.
        rdy15 = 1'b1;
        q15.push_back(3);
        for (int i = 0; i < 16; i++) samp15(3);
        tick();
        check("t1_valid_edge2", int'(bus15.avg_valid), 0);
        tick();
        check("t1_valid_edge3", int'(bus15.avg_valid), 1);
        check("t1_ovf", int'(ovf15), 0);
        drain15("t1_drain");

        // 2: alternating -7/-8, window sum -120.
        reset_dut();
        q15.push_back(rnd_or(-8, -7));
        for (int i = 0; i < 16; i++) samp15((i % 2 == 0) ? -7 : -8);
        drain15("t2_drain");

        // 3: sum passes 0x1FFFFF0 then wraps to 0x0000010.
        reset_dut();
        q15.push_back(-1);
        q15.push_back(2);
        for (int i = 0; i < 16; i++) samp15(-1);
        for (int i = 0; i < 16; i++) samp15(2);
        check("t3_sum_wrapped", int'(acc), 32'h10);
        drain15("t3_drain");

        // 4: backpressure over three windows; third result is dropped.
        reset_dut();
        rdy15 = 1'b0;
        q15.push_back(1);
        q15.push_back(2);
        for (int w = 1; w <= 3; w++) begin
            for (int i = 0; i < 16; i++) samp15(w);
        end
        for (int i = 0; i < 4; i++) tick();
        check("t4_ovf_set", int'(ovf15), 1);
        check("t4_valid_held", int'(bus15.avg_valid), 1);
        check("t4_head_held", int'($signed(bus15.avg_data)), 1);
        rdy15 = 1'b1;
        drain15("t4_drain");
        check("t4_empty", int'(bus15.avg_valid), 0);
        check("t4_ovf_sticky", int'(ovf15), 1);

        // 5: sample_en held high, captures land on back-to-back windows.
        reset_dut();
        for (int i = 0; i < 4; i++) q15.push_back(5);
        en15 = 1'b1;
        x_in = 25'(5);
        for (int i = 0; i < 64; i++) tick();
        en15 = 1'b0;
        drain15("t5_drain");
        check("t5_ovf", int'(ovf15), 0);

        // 6: saturation on the 8-bit instance, then mid-window reset.
        reset_dut();
        rdy8 = 1'b0;
        q8.push_back(127);
        q8.push_back(-128);
        for (int i = 0; i < 16; i++) samp8(200);
        for (int i = 0; i < 16; i++) samp8(-300);
        for (int i = 0; i < 16; i++) samp8(200);
        for (int i = 0; i < 4; i++) tick();
        check("t6_ovf_set", int'(ovf8), 1);
        rdy8 = 1'b1;
        drain8("t6_drain_sat");
        check("t6_ovf_sticky", int'(ovf8), 1);
        for (int i = 0; i < 7; i++) samp8(200);
        reset_dut();
        check("t6_rst_valid", int'(bus8.avg_valid), 0);
        check("t6_rst_ovf", int'(ovf8), 0);
        q8.push_back(10);
        for (int i = 0; i < 16; i++) samp8(10);
        drain8("t6_drain_after_rst");
        check("t15_no_stray", q15.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_average_dump.md
Name: window_average_dump

Overview:
- Consumes the running sum of the upstream sign-extending accumulator, which counts on its enable and never self-clears.
- Counts the accumulator's enable pulses. After every 2^LOG2_WIN samples, snapshots the sum and forms the window sum as the difference from the previous snapshot (wrap-safe).
- Divides that window sum by 2^LOG2_WIN with an arithmetic shift and saturates it to OUT_W.
- Presents results on a valid/ready stream through a 2-entry output FIFO. This gives per-window averages without ever resetting the accumulator.

Parameters:
- SUM_W, 25: width of sum_in; must equal the accumulator sum width.
- LOG2_WIN, 4: window length is 2^LOG2_WIN samples. Constraint: IN_W+LOG2_WIN <= SUM_W (checked by elaboration assertion).
- IN_W, 15: upstream sample width; used only for the constraint check.
- OUT_W, 15: output average width, signed two's complement.

Ports:
- clk in 1: clock; same clock as the accumulator.
- reset in 1: reset, asynchronous, active-high. Must be the same net that resets the accumulator.
- sample_en in 1: the accumulator's enable. High means the accumulator adds a sample at this edge.
- sum_in in SUM_W: the accumulator's Sum output.
- avg_data out OUT_W: head-of-FIFO average, signed.
- avg_valid out 1: FIFO not empty.
- avg_ready in 1: consumer accepts; a transfer occurs when avg_valid && avg_ready at the edge.
- ovf out 1: sticky flag; a result was dropped because the FIFO was full.

Behaviour:
- Reset (async) values:
  - cnt=0, base=0 (matches accumulator reset value 0), state=COUNT.
  - FIFO empty, so avg_valid=0.
  - avg_data=0, ovf=0.
- Reset mid-window discards the partial window and all buffered results.
- State machine:
  - COUNT: each edge with sample_en=1 increments cnt (LOG2_WIN bits). When sample_en=1 and cnt==2^LOG2_WIN-1, cnt wraps to 0 and the next state is CAPTURE.
  - CAPTURE (exactly one cycle): sum_in now includes the last sample of the window. Register diff = sum_in - base (mod 2^SUM_W, interpreted signed), set base <= sum_in, and return to COUNT.
  - A sample_en in the CAPTURE cycle counts as sample 1 of the next window (cnt increments). That sample's update is not yet visible in sum_in, so the snapshot stays exact.
- Arithmetic:
  - avg = diff >>> LOG2_WIN (arithmetic shift, floor toward -inf).
  - Saturate to OUT_W: values above 2^(OUT_W-1)-1 clamp to the maximum; values below -2^(OUT_W-1) clamp to the minimum.
- Pipeline and latency:
  - One register stage for diff/avg, then the FIFO push.
  - The result is at the FIFO tail 2 cycles after the last window sample edge. avg_valid rises on the third edge if the FIFO was empty.
- FIFO (depth 2, in-order):
  - Push and pop in the same cycle when full: the pop frees the slot, so the push is accepted.
  - Push when full without a pop: the new result is dropped, the FIFO contents are untouched, and ovf <= 1. ovf is cleared only by reset.
  - avg_data holds the head entry stable while avg_valid=1 && avg_ready=0.
  - When empty, avg_data keeps its last value; it is don't-care.
- Wrap-around: sum_in and base wrap freely. The modular subtraction gives the correct window sum as long as the constraint on IN_W+LOG2_WIN holds.

Optional Feature:
- Macro WINDOW_AVERAGE_ROUND_EN.
- When defined: before the shift, add 2^(LOG2_WIN-1) to diff (round half up). The addition is done at SUM_W+1 bits so it cannot overflow, then the result is saturated.
- When undefined: truncating floor shift only.
- Rounding adds no latency in either case.

Decomposition:
- Shared package window_avg_pkg holds:
  - state enum {COUNT, CAPTURE};
  - saturation function sat_signed(value, width);
  - FIFO_DEPTH=2 constant.
- One sub-module: result_fifo2 (parameterised width, 2 entries, valid/ready, full/push_drop output). The parent handles counting, capture and arithmetic.

Test Plan:
1. Reset, then 16 pulses of sample_en with the accumulator model adding +3 each (sum_in reaches 48). Expect avg_data=3, avg_valid on the 3rd edge after the 16th sample, ovf=0.
2. 16 samples alternating -7/-8 (window sum -120). Expect avg_data=-8; with WINDOW_AVERAGE_ROUND_EN, expect -7.
3. Wrap: drive sum_in directly. First window ends at 0x1FFFFF0, next ends at 0x0000010. Expect second avg=2 (diff 32).
4. Backpressure: avg_ready=0 over 3 windows of values 1, 2, 3. Expect the FIFO to hold 1 and 2, 3 dropped, ovf=1. Then avg_ready=1 gives 1, 2 in order, then avg_valid=0, and ovf stays 1.
5. sample_en held high continuously (a capture every 16 cycles, samples during CAPTURE included). With constant +5 input, every window result is exactly 5; no window loses or gains a sample.
6. OUT_W=8, samples of +200 → avg_data=127; samples of -300 → -128. Then reset asserted after 7 samples → cnt=0, FIFO empty, ovf=0, and the next full window yields the correct average.
